pong_game_sequencer: RTL and testbench
======================================

Name: pong_game_sequencer

Overview:
- Match-level controller for the pong datapath. It sequences attract, serve delay, rally, point pause and game over.
- It owns both BCD scores and gates ball motion through ball_run and ball_center.
- It arbitrates sound-effect requests from collision events into a single tone request for the speaker tone generator.
- It is clocked by the pixel clock and advances its timers on a one-cycle-per-frame tick derived from vsync.

Parameters:
SERVE_FRAMES, 60, number of frame ticks spent in SERVE before the ball moves (range 1..1023)
POINT_FRAMES, 45, number of frame ticks of freeze after a point (range 1..1023)
WIN_SCORE, 9, score that ends the match (range 1..9, single BCD digit)
OVER_FRAMES, 255, number of frame ticks in GAME_OVER before auto-return to IDLE (used only with AUTO_RESTART_EN)

Ports:
clk  in  1  pixel clock
reset  in  1  asynchronous reset, active high
frame_tick  in  1  one-cycle pulse, once per frame
start_btn  in  1  start button level, already synchronised; rising edge is used
miss_left  in  1  pulse: ball passed the left boundary; point to player 1
miss_right  in  1  pulse: ball passed the right boundary; point to player 0
paddle_hit  in  1  pulse: ball/paddle collision
ball_run  out  1  1 = ball position may update on frame ticks
ball_center  out  1  one-cycle pulse: recentre the ball
serve_dir  out  1  0 = serve toward +x, 1 = toward -x
score0_bcd  out  4  player 0 score
score1_bcd  out  4  player 1 score
winner  out  2  00 none, 01 player 0, 10 player 1
state  out  3  IDLE=0, SERVE=1, RALLY=2, POINT=3, OVER=4
tone_req  out  1  one-cycle pulse requesting a tone
tone_sel  out  2  tone id, valid with tone_req: 1 paddle, 2 point, 3 game over

Behaviour:
- Clock and reset: single clock domain. Reset is asynchronous, active high.
- Reset values: state IDLE, every output 0, timer 0, start edge register 0.
- Latency: all outputs are registered and change on the edge after the causing input.
- Start edge: start_rise = start_btn & ~start_q.
- Frame timer: 10-bit down counter, loaded with N-1 on state entry. On a frame_tick with timer==0 the state exits; on other ticks the timer decrements. The dwell is therefore exactly N ticks.
- IDLE: ball_run=0. On start_rise: scores←0, winner←0, serve_dir←0, ball_center pulse, go to SERVE.
- SERVE:
  - ball_run=0.
  - miss_* and paddle_hit are ignored.
  - After SERVE_FRAMES ticks, go to RALLY.
- RALLY:
  - ball_run=1.
  - miss_left: score1 +1. miss_right: score0 +1.
  - If both misses arrive in the same cycle, only miss_left is taken.
  - serve_dir←1 after miss_left, 0 after miss_right (the serve goes toward the player who conceded).
  - If the new score == WIN_SCORE: set winner and go to OVER. Otherwise go to POINT.
  - ball_run is 0 from the cycle after the miss.
  - paddle_hit gives tone_req with sel 1.
- POINT: ball_run=0. After POINT_FRAMES ticks: ball_center pulse, go to SERVE.
- OVER:
  - ball_run=0. Scores and winner are held.
  - start_rise restarts exactly as from IDLE.
- start_rise in SERVE, RALLY or POINT: ignored.
- Tone arbitration, one request per cycle, priority 3 > 2 > 1:
  - A point gives sel 2; a winning point gives sel 3.
  - paddle_hit in the same cycle as a miss is dropped.
- Scores never exceed WIN_SCORE, so no BCD carry is needed.
- frame_tick arriving in the same cycle as an event: the event is processed, and the new state's timer load takes precedence over any decrement.
- Reset mid-match: immediate return to IDLE with scores cleared.

Optional Feature:
- Macro: PONG_SEQ_AUTO_RESTART_EN.
- Defined: OVER exits to IDLE after OVER_FRAMES ticks (timer loaded on entry). Scores and winner are held in IDLE until the next start_rise. start_rise during OVER still restarts immediately.
- Undefined: OVER is left only via start_rise or reset, and the OVER_FRAMES parameter is unused.

Test Plan:
- Reset, then start_btn 0→1 -> one ball_center pulse; state 1; scores 0; ball_run rises exactly 60 frame_ticks later (SERVE_FRAMES=60).
- In RALLY, pulse miss_right -> score0_bcd=1, serve_dir=0, tone_req with sel 2, ball_run=0 next cycle; after 45 ticks: ball_center pulse, state 1.
- miss_left and miss_right in the same cycle -> only score1_bcd increments (score0 unchanged); single tone_req with sel 2.
- WIN_SCORE=3, three miss_left points -> winner=10, state 4, tone_sel 3; a later start_rise -> scores 0, winner 00, state 1.
- paddle_hit during SERVE -> no tone_req. During RALLY -> tone_req with sel 1. start_rise mid-RALLY -> ignored.
- Assert reset asynchronously in POINT with a nonzero score -> outputs 0 without waiting for a clk edge. Separately, with PONG_SEQ_AUTO_RESTART_EN defined and OVER_FRAMES=4 -> state 0 after the 4th tick with scores held.

Source files
------------

// File: rtl/pong_game_sequencer.sv
// Match-level sequencer for pong: attract, serve delay, rally, point pause and game over,
// with BCD scoring and tone arbitration. PONG_SEQ_AUTO_RESTART_EN enables OVER -> IDLE timeout.
module pong_game_sequencer #(
    parameter int unsigned SERVE_FRAMES = 60,
    parameter int unsigned POINT_FRAMES = 45,
    parameter int unsigned WIN_SCORE    = 9,
    parameter int unsigned OVER_FRAMES  = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic       miss_left,
    input  logic       miss_right,
    input  logic       paddle_hit,
    output logic       ball_run,
    output logic       ball_center,
    output logic       serve_dir,
    output logic [3:0] score0_bcd,
    output logic [3:0] score1_bcd,
    output logic [1:0] winner,
    output logic [2:0] state,
    output logic       tone_req,
    output logic [1:0] tone_sel
);

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StServe = 3'd1,
        StRally = 3'd2,
        StPoint = 3'd3,
        StOver  = 3'd4
    } state_e;

    localparam logic [9:0] ServeLoad = 10'(SERVE_FRAMES - 1);
    localparam logic [9:0] PointLoad = 10'(POINT_FRAMES - 1);
    localparam logic [9:0] OverLoad  = 10'(OVER_FRAMES - 1);
    localparam logic [3:0] WinDigit  = 4'(WIN_SCORE);

    localparam logic [1:0] ToneNone   = 2'd0;
    localparam logic [1:0] TonePaddle = 2'd1;
    localparam logic [1:0] TonePoint  = 2'd2;
    localparam logic [1:0] ToneOver   = 2'd3;

    state_e     state_q, state_d;
    logic [9:0] timer_q, timer_d;
    logic       start_q, start_d;
    logic [3:0] score0_q, score0_d;
    logic [3:0] score1_q, score1_d;
    logic [1:0] winner_q, winner_d;
    logic       serve_dir_q, serve_dir_d;
    logic       ball_run_q, ball_run_d;
    logic       ball_center_q, ball_center_d;
    logic       tone_req_q, tone_req_d;
    logic [1:0] tone_sel_q, tone_sel_d;

    logic       start_rise;
    logic       restart;
    logic       point;
    logic       won;
    logic [3:0] score0_inc;
    logic [3:0] score1_inc;

    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        start_d       = start_btn;
        score0_d      = score0_q;
        score1_d      = score1_q;
        winner_d      = winner_q;
        serve_dir_d   = serve_dir_q;
        ball_center_d = 1'b0;
        tone_req_d    = 1'b0;
        tone_sel_d    = ToneNone;
        point         = 1'b0;
        won           = 1'b0;
        score0_inc    = score0_q + 4'd1;
        score1_inc    = score1_q + 4'd1;

        start_rise = start_btn & ~start_q;
        restart    = start_rise && ((state_q == StIdle) || (state_q == StOver));

        case (state_q)
            StServe: begin
                if (frame_tick) begin
                    if (timer_q == '0) begin
                        state_d = StRally;
                    end else begin
                        timer_d = timer_q - 10'd1;
                    end
                end
            end
            StRally: begin
                // miss_left wins a simultaneous double miss
                if (miss_left) begin
                    score1_d    = score1_inc;
                    serve_dir_d = 1'b1;
                    point       = 1'b1;
                    won         = (score1_inc == WinDigit);
                end else if (miss_right) begin
                    score0_d    = score0_inc;
                    serve_dir_d = 1'b0;
                    point       = 1'b1;
                    won         = (score0_inc == WinDigit);
                end

                if (point) begin
                    tone_req_d = 1'b1;
                    if (won) begin
                        winner_d   = miss_left ? 2'b10 : 2'b01;
                        state_d    = StOver;
                        timer_d    = OverLoad;
                        tone_sel_d = ToneOver;
                    end else begin
                        state_d    = StPoint;
                        timer_d    = PointLoad;
                        tone_sel_d = TonePoint;
                    end
                end else if (paddle_hit) begin
                    tone_req_d = 1'b1;
                    tone_sel_d = TonePaddle;
                end
            end
            StPoint: begin
                if (frame_tick) begin
                    if (timer_q == '0) begin
                        state_d       = StServe;
                        timer_d       = ServeLoad;
                        ball_center_d = 1'b1;
                    end else begin
                        timer_d = timer_q - 10'd1;
                    end
                end
            end
            StOver: begin
`ifdef PONG_SEQ_AUTO_RESTART_EN
                // Scores and winner stay visible in IDLE until the next start
                if (frame_tick) begin
                    if (timer_q == '0) begin
                        state_d = StIdle;
                    end else begin
                        timer_d = timer_q - 10'd1;
                    end
                end
`else
                state_d = StOver;
`endif
            end
            StIdle: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        if (restart) begin
            state_d       = StServe;
            timer_d       = ServeLoad;
            score0_d      = 4'd0;
            score1_d      = 4'd0;
            winner_d      = 2'b00;
            serve_dir_d   = 1'b0;
            ball_center_d = 1'b1;
        end

        ball_run_d = (state_d == StRally);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StIdle;
            timer_q       <= '0;
            start_q       <= 1'b0;
            score0_q      <= '0;
            score1_q      <= '0;
            winner_q      <= '0;
            serve_dir_q   <= 1'b0;
            ball_run_q    <= 1'b0;
            ball_center_q <= 1'b0;
            tone_req_q    <= 1'b0;
            tone_sel_q    <= '0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            start_q       <= start_d;
            score0_q      <= score0_d;
            score1_q      <= score1_d;
            winner_q      <= winner_d;
            serve_dir_q   <= serve_dir_d;
            ball_run_q    <= ball_run_d;
            ball_center_q <= ball_center_d;
            tone_req_q    <= tone_req_d;
            tone_sel_q    <= tone_sel_d;
        end
    end

    assign ball_run    = ball_run_q;
    assign ball_center = ball_center_q;
    assign serve_dir   = serve_dir_q;
    assign score0_bcd  = score0_q;
    assign score1_bcd  = score1_q;
    assign winner      = winner_q;
    assign state       = state_q;
    assign tone_req    = tone_req_q;
    assign tone_sel    = tone_sel_q;

endmodule

// File: tb/tb_pong_game_sequencer.sv
// Table-driven bench for pong_game_sequencer (SERVE 60, POINT 45, WIN 3, OVER 4),
// plus a hand-written asynchronous reset sequence.
module tb_pong_game_sequencer;

    logic       clk;
    logic       reset;
    logic       frame_tick;
    logic       start_btn;
    logic       miss_left;
    logic       miss_right;
    logic       paddle_hit;
    logic       ball_run;
    logic       ball_center;
    logic       serve_dir;
    logic [3:0] score0_bcd;
    logic [3:0] score1_bcd;
    logic [1:0] winner;
    logic [2:0] state;
    logic       tone_req;
    logic [1:0] tone_sel;

    int checks = 0;
    int errors = 0;
    int cur_step = -1;

`ifdef PONG_SEQ_AUTO_RESTART_EN
    localparam int AutoRestart = 1;
`else
    localparam int AutoRestart = 0;
`endif

    pong_game_sequencer #(
        .SERVE_FRAMES(60),
        .POINT_FRAMES(45),
        .WIN_SCORE   (3),
        .OVER_FRAMES (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .start_btn  (start_btn),
        .miss_left  (miss_left),
        .miss_right (miss_right),
        .paddle_hit (paddle_hit),
        .ball_run   (ball_run),
        .ball_center(ball_center),
        .serve_dir  (serve_dir),
        .score0_bcd (score0_bcd),
        .score1_bcd (score1_bcd),
        .winner     (winner),
        .state      (state),
        .tone_req   (tone_req),
        .tone_sel   (tone_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ticks: frame ticks (each followed by an idle cycle) issued before the event cycle
    typedef struct {
        int         ticks;
        logic       start;
        logic       ml;
        logic       mr;
        logic       ph;
        logic       tk;
        logic [2:0] st;
        logic       run;
        logic       ctr;
        logic       req;
        logic [1:0] sel;
        logic [3:0] s0;
        logic [3:0] s1;
        logic [1:0] win;
        logic       dir;
    } vec_t;

    localparam int NumVecs = 23;
    vec_t vecs[NumVecs];

    function automatic vec_t mk(int ticks, bit start, bit ml, bit mr, bit ph, bit tk,
                                int st, bit run, bit ctr, bit req, int sel,
                                int s0, int s1, int win, bit dir);
        vec_t v;
        v.ticks = ticks;
        v.start = start;
        v.ml    = ml;
        v.mr    = mr;
        v.ph    = ph;
        v.tk    = tk;
        v.st    = 3'(st);
        v.run   = run;
        v.ctr   = ctr;
        v.req   = req;
        v.sel   = 2'(sel);
        v.s0    = 4'(s0);
        v.s1    = 4'(s1);
        v.win   = 2'(win);
        v.dir   = dir;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s (step %0d): got %0d, expected %0d", name, cur_step, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input vec_t v);
        chk("state", int'(state), int'(v.st));
        chk("ball_run", int'(ball_run), int'(v.run));
        chk("ball_center", int'(ball_center), int'(v.ctr));
        chk("tone_req", int'(tone_req), int'(v.req));
        chk("tone_sel", int'(tone_sel), int'(v.sel));
        chk("score0", int'(score0_bcd), int'(v.s0));
        chk("score1", int'(score1_bcd), int'(v.s1));
        chk("winner", int'(winner), int'(v.win));
        chk("serve_dir", int'(serve_dir), int'(v.dir));
    endtask

    task automatic apply(input vec_t v);
        for (int k = 0; k < v.ticks; k++) begin
            frame_tick = 1'b1;
            cycle();
            frame_tick = 1'b0;
            cycle();
        end
        start_btn  = v.start;
        miss_left  = v.ml;
        miss_right = v.mr;
        paddle_hit = v.ph;
        frame_tick = v.tk;
        cycle();
        check_all(v);
        miss_left  = 1'b0;
        miss_right = 1'b0;
        paddle_hit = 1'b0;
        frame_tick = 1'b0;
    endtask

    initial begin
        vec_t zero_v;

        //             tk st ml mr ph tk  st run ctr req sel s0 s1 win dir
        vecs[0]  = mk(0, 1, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0, 0, 0);  // start rise
        vecs[1]  = mk(58, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0);  // 59th tick: still serving
        vecs[2]  = mk(0, 1, 0, 0, 0, 1,  2, 1, 0, 0, 0, 0, 0, 0, 0);  // 60th tick: rally
        vecs[3]  = mk(0, 1, 0, 0, 1, 0,  2, 1, 0, 1, 1, 0, 0, 0, 0);  // paddle tone
        vecs[4]  = mk(0, 0, 0, 0, 0, 0,  2, 1, 0, 0, 0, 0, 0, 0, 0);
        vecs[5]  = mk(0, 1, 0, 0, 0, 0,  2, 1, 0, 0, 0, 0, 0, 0, 0);  // start rise ignored
        vecs[6]  = mk(0, 1, 0, 1, 0, 1,  3, 0, 0, 1, 2, 1, 0, 0, 0);  // miss_right + tick
        vecs[7]  = mk(43, 1, 0, 0, 0, 1, 3, 0, 0, 0, 0, 1, 0, 0, 0);  // 44th point tick
        vecs[8]  = mk(0, 1, 0, 0, 0, 1,  1, 0, 1, 0, 0, 1, 0, 0, 0);  // 45th: recentre
        vecs[9]  = mk(0, 1, 0, 0, 1, 0,  1, 0, 0, 0, 0, 1, 0, 0, 0);  // paddle in serve
        vecs[10] = mk(59, 1, 0, 0, 0, 1, 2, 1, 0, 0, 0, 1, 0, 0, 0);
        vecs[11] = mk(0, 1, 1, 1, 1, 0,  3, 0, 0, 1, 2, 1, 1, 0, 1);  // double miss + paddle
        vecs[12] = mk(44, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 1, 1, 0, 1);
        vecs[13] = mk(59, 1, 0, 0, 0, 1, 2, 1, 0, 0, 0, 1, 1, 0, 1);
        vecs[14] = mk(0, 1, 1, 0, 0, 0,  3, 0, 0, 1, 2, 1, 2, 0, 1);
        vecs[15] = mk(44, 1, 0, 0, 0, 1, 1, 0, 1, 0, 0, 1, 2, 0, 1);
        vecs[16] = mk(59, 1, 0, 0, 0, 1, 2, 1, 0, 0, 0, 1, 2, 0, 1);
        vecs[17] = mk(0, 1, 1, 0, 0, 0,  4, 0, 0, 1, 3, 1, 3, 2, 1);  // winning point
        vecs[18] = mk(2, 1, 0, 0, 0, 1,  4, 0, 0, 0, 0, 1, 3, 2, 1);  // 3rd over tick
        vecs[19] = mk(0, 0, 0, 0, 0, 1,  AutoRestart != 0 ? 0 : 4,
                      0, 0, 0, 0, 1, 3, 2, 1);                          // 4th over tick
        vecs[20] = mk(0, 1, 0, 0, 0, 0,  1, 0, 1, 0, 0, 0, 0, 0, 0);  // restart
        vecs[21] = mk(59, 1, 0, 0, 0, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0);
        vecs[22] = mk(0, 1, 0, 1, 0, 0,  3, 0, 0, 1, 2, 1, 0, 0, 0);  // into POINT, score0=1

        reset      = 1'b1;
        frame_tick = 1'b0;
        start_btn  = 1'b0;
        miss_left  = 1'b0;
        miss_right = 1'b0;
        paddle_hit = 1'b0;

        zero_v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        check_all(zero_v);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        cycle();
        check_all(zero_v);

        for (int i = 0; i < NumVecs; i++) begin
            cur_step = i;
            apply(vecs[i]);
        end

        // Asynchronous reset in POINT: outputs clear before any clock edge
        cur_step = 100;
        chk("pre_reset_score0", int'(score0_bcd), 1);
        #2;
        reset = 1'b1;
        #1;
        check_all(zero_v);
        #1;
        reset     = 1'b0;
        start_btn = 1'b0;
        cur_step  = 101;
        cycle();
        cycle();
        check_all(zero_v);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
